// File: rtl/twdl_cmul_pfa.sv
// Twiddle complex multiply for the PFA datapath: 4-stage pipeline, round/saturate, lane mask.
// Define CONV_ROUND_EN for round-half-to-even; the default build rounds half toward +inf.
module twdl_cmul_pfa #(
  parameter int unsigned wDataInOut = 30,
  parameter int unsigned wTw        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 factor,
  input  logic                       in_val,
  input  logic [0:4][wDataInOut-1:0] din_real,
  input  logic [0:4][wDataInOut-1:0] din_imag,
  input  logic [0:4][wTw-1:0]        tw_real,
  input  logic [0:4][wTw-1:0]        tw_imag,
  input  logic                       sat_clr,
  output logic                       out_val,
  output logic [0:4][wDataInOut-1:0] dout_real,
  output logic [0:4][wDataInOut-1:0] dout_imag,
  output logic                       sat_sticky
);

  localparam int unsigned LANES = 5;
  localparam int unsigned DW    = wDataInOut;
  localparam int unsigned PW    = wDataInOut + wTw;
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned RW    = SW + 1;
  localparam int unsigned FRAC  = wTw - 2;

  logic             s1_val;
  logic             s2_val;
  logic             s3_val;
  logic [2:0]       s1_factor;
  logic [2:0]       s1_eff;
  logic [LANES-1:0] s1_en;
  logic [LANES-1:0] s2_en;
  logic [LANES-1:0] s3_en;
  logic [LANES-1:0] lane_sat;

  // Returns {saturated, value}: round the Q(FRAC) sum back to DW bits and clamp.
  function automatic logic [DW:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] q;
    logic [RW-DW:0]       hi;
    logic                 inc;
    inc = 1'b1;
`ifdef CONV_ROUND_EN
    if ((x[FRAC-1:0] == {1'b1, {(FRAC-1){1'b0}}}) && !x[FRAC]) inc = 1'b0;
`endif
    sum = RW'(x) + RW'({inc, {(FRAC-1){1'b0}}});
    q   = sum >>> FRAC;
    hi  = q[RW-1:DW-1];
    if ((&hi) || !(|hi)) return {1'b0, q[DW-1:0]};
    return {1'b1, q[RW-1], {(DW-1){!q[RW-1]}}};
  endfunction

  // Out-of-range radix codes behave as a full radix-5 beat.
  always_comb begin
    s1_eff = s1_factor;
    if ((s1_factor < 3'd2) || (s1_factor > 3'd5)) s1_eff = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val     <= 1'b0;
      s1_factor  <= '0;
      s2_val     <= 1'b0;
      s2_en      <= '0;
      s3_val     <= 1'b0;
      s3_en      <= '0;
      out_val    <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      s1_val     <= in_val;
      s1_factor  <= factor;
      s2_val     <= s1_val;
      s2_en      <= s1_en;
      s3_val     <= s2_val;
      s3_en      <= s2_en;
      out_val    <= s3_val;
      sat_sticky <= (s3_val && (|lane_sat)) || (sat_sticky && !sat_clr);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DW-1:0]  dr1;
    logic signed [DW-1:0]  di1;
    logic signed [wTw-1:0] tr1;
    logic signed [wTw-1:0] ti1;
    logic signed [PW-1:0]  rr2;
    logic signed [PW-1:0]  ii2;
    logic signed [PW-1:0]  ri2;
    logic signed [PW-1:0]  ir2;
    logic signed [SW-1:0]  re3;
    logic signed [SW-1:0]  im3;
    logic [DW:0]           re_rs;
    logic [DW:0]           im_rs;
    logic [DW-1:0]         re_q;
    logic [DW-1:0]         im_q;

    assign s1_en[g]    = (3'(g) < s1_eff);
    assign re_rs       = round_sat(re3);
    assign im_rs       = round_sat(im3);
    assign lane_sat[g] = s3_en[g] && (re_rs[DW] || im_rs[DW]);

    always_ff @(posedge clk) begin
      if (rst) begin
        dr1  <= '0;
        di1  <= '0;
        tr1  <= '0;
        ti1  <= '0;
        rr2  <= '0;
        ii2  <= '0;
        ri2  <= '0;
        ir2  <= '0;
        re3  <= '0;
        im3  <= '0;
        re_q <= '0;
        im_q <= '0;
      end else begin
        dr1  <= din_real[g];
        di1  <= din_imag[g];
        tr1  <= tw_real[g];
        ti1  <= tw_imag[g];
        rr2  <= PW'(dr1) * PW'(tr1);
        ii2  <= PW'(di1) * PW'(ti1);
        ri2  <= PW'(dr1) * PW'(ti1);
        ir2  <= PW'(di1) * PW'(tr1);
        re3  <= SW'(rr2) - SW'(ii2);
        im3  <= SW'(ri2) + SW'(ir2);
        re_q <= (s3_val && s3_en[g]) ? re_rs[DW-1:0] : '0;
        im_q <= (s3_val && s3_en[g]) ? im_rs[DW-1:0] : '0;
      end
    end

    assign dout_real[g] = re_q;
    assign dout_imag[g] = im_q;
  end

endmodule

// File: tb/tb_twdl_cmul_pfa.sv
// Bench for twdl_cmul_pfa: cycle-indexed input history feeds a behavioural model, plus literal pins.
module tb_twdl_cmul_pfa;

  localparam int NC   = 1024;
  localparam int DMAX = 536870911;
  localparam int DMIN = -536870912;
`ifdef CONV_ROUND_EN
  localparam int RND5 = 2;
`else
  localparam int RND5 = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_val;
  logic             sat_clr;
  logic             out_val;
  logic             sat_sticky;
  logic [2:0]       factor;
  logic [0:4][29:0] din_real;
  logic [0:4][29:0] din_imag;
  logic [0:4][29:0] dout_real;
  logic [0:4][29:0] dout_imag;
  logic [0:4][15:0] tw_real;
  logic [0:4][15:0] tw_imag;

  always #5 clk = ~clk;

  twdl_cmul_pfa dut (
    .clk       (clk),
    .rst       (rst),
    .factor    (factor),
    .in_val    (in_val),
    .din_real  (din_real),
    .din_imag  (din_imag),
    .tw_real   (tw_real),
    .tw_imag   (tw_imag),
    .sat_clr   (sat_clr),
    .out_val   (out_val),
    .dout_real (dout_real),
    .dout_imag (dout_imag),
    .sat_sticky(sat_sticky)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int     c;
    int     kind;
    int     lane;
    longint a;
    longint b;
  } pin_t;
  pin_t pins[$];

  bit h_v[NC];
  bit h_r[NC];
  bit h_c[NC];
  int h_f[NC];
  int h_dr[NC][5];
  int h_di[NC][5];
  int h_tr[NC][5];
  int h_ti[NC][5];

  bit     armed = 1'b0;
  bit     m_st  = 1'b0;
  bit     ev;
  bit     sb;
  bit     s_re;
  bit     s_im;
  int     eff;
  longint er[5];
  longint ei[5];

  task automatic chk(input string nm, input int lane, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d lane=%0d got=%0d want=%0d", nm, cyc, lane, got, want);
    end
  endtask

  // Exact product in Q14, rounded and clamped to the 30-bit signed output range.
  function automatic longint rnd_sat(input longint x, output bit sat);
    longint fl;
    longint frac;
    longint q;
    fl   = x >>> 14;
    frac = x - fl * 16384;
    q    = fl;
`ifdef CONV_ROUND_EN
    if ((frac > 8192) || ((frac == 8192) && fl[0])) q = fl + 1;
`else
    if (frac >= 8192) q = fl + 1;
`endif
    sat = 1'b0;
    if (q > DMAX) begin q = DMAX; sat = 1'b1; end
    if (q < DMIN) begin q = DMIN; sat = 1'b1; end
    return q;
  endfunction

  function automatic bit flushed(input int t);
    for (int k = t - 4; k < t; k++) if ((k < 0) || h_r[k]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (cyc < NC) begin
      h_v[cyc] = in_val;
      h_r[cyc] = rst;
      h_c[cyc] = sat_clr;
      h_f[cyc] = int'(factor);
      for (int l = 0; l < 5; l++) begin
        h_dr[cyc][l] = int'($signed(din_real[l]));
        h_di[cyc][l] = int'($signed(din_imag[l]));
        h_tr[cyc][l] = int'($signed(tw_real[l]));
        h_ti[cyc][l] = int'($signed(tw_imag[l]));
      end
      ev = 1'b0;
      sb = 1'b0;
      for (int l = 0; l < 5; l++) begin er[l] = 0; ei[l] = 0; end
      if ((cyc >= 4) && !flushed(cyc) && h_v[cyc-4]) begin
        ev  = 1'b1;
        eff = h_f[cyc-4];
        if ((eff < 2) || (eff > 5)) eff = 5;
        for (int l = 0; l < eff; l++) begin
          er[l] = rnd_sat(longint'(h_dr[cyc-4][l]) * h_tr[cyc-4][l]
                        - longint'(h_di[cyc-4][l]) * h_ti[cyc-4][l], s_re);
          ei[l] = rnd_sat(longint'(h_dr[cyc-4][l]) * h_ti[cyc-4][l]
                        + longint'(h_di[cyc-4][l]) * h_tr[cyc-4][l], s_im);
          sb = sb | s_re | s_im;
        end
      end
      if (cyc >= 1) begin
        if (h_r[cyc-1]) begin
          m_st  = 1'b0;
          armed = 1'b1;
        end else begin
          m_st = sb | (m_st & !h_c[cyc-1]);
        end
      end
      if (armed) begin
        chk("out_val", -1, longint'(out_val), longint'(ev));
        for (int l = 0; l < 5; l++) begin
          chk("dout_real", l, longint'($signed(dout_real[l])), er[l]);
          chk("dout_imag", l, longint'($signed(dout_imag[l])), ei[l]);
        end
        chk("sat_sticky", -1, longint'(sat_sticky), longint'(m_st));
      end
      foreach (pins[k]) begin
        if (pins[k].c == cyc) begin
          case (pins[k].kind)
            0: begin
              chk("pin_real", pins[k].lane, longint'($signed(dout_real[pins[k].lane])), pins[k].a);
              chk("pin_imag", pins[k].lane, longint'($signed(dout_imag[pins[k].lane])), pins[k].b);
            end
            1: chk("pin_out_val", -1, longint'(out_val), pins[k].a);
            default: chk("pin_sticky", -1, longint'(sat_sticky), pins[k].a);
          endcase
        end
      end
    end
    cyc++;
  end

  task automatic add_pin(input int dc, input int kind, input int lane, input longint a, input longint b);
    pin_t p;
    p.c = cyc + dc; p.kind = kind; p.lane = lane; p.a = a; p.b = b;
    pins.push_back(p);
  endtask

  task automatic pin_lane(input int dc, input int l, input longint re, input longint im);
    add_pin(dc, 0, l, re, im);
  endtask

  task automatic set_lane(input int l, input int dr, input int di, input int tr, input int ti);
    din_real[l] = 30'(dr);
    din_imag[l] = 30'(di);
    tw_real[l]  = 16'(tr);
    tw_imag[l]  = 16'(ti);
  endtask

  task automatic set_all(input int dr, input int di, input int tr, input int ti);
    for (int l = 0; l < 5; l++) set_lane(l, dr, di, tr, ti);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int f);
    in_val = 1'b1;
    factor = 3'(f);
    tick();
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; sat_clr = 1'b0; factor = 3'd5;
    set_all(0, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    add_pin(0, 1, 0, 0, 0);
    add_pin(0, 2, 0, 0, 0);
    pin_lane(0, 0, 0, 0);

    // unity twiddle
    set_all(1000, -7, 16384, 0);
    for (int l = 0; l < 5; l++) pin_lane(4, l, 1000, -7);
    add_pin(4, 1, 0, 1, 0);
    add_pin(5, 1, 0, 0, 0);
    add_pin(4, 2, 0, 0, 0);
    beat(5);
    idle(1);

    // -j twiddle on lane 2
    set_all(1000, -7, 16384, 0);
    set_lane(2, 3, 5, 0, -16384);
    pin_lane(4, 2, 5, -3);
    beat(5);

    // eight back-to-back beats
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 100 + k, 2 * k - 3, 16384, 0);
      set_lane(1, 100 + k, 2 * k - 3, 0, -16384);
      set_lane(2, 100 + k, 2 * k - 3, 8192, 8192);
      set_lane(3, 100 + k, 2 * k - 3, -16384, 0);
      set_lane(4, 100 + k, 2 * k - 3, 11585, -11585);
      pin_lane(4, 0, 100 + k, 2 * k - 3);
      pin_lane(4, 1, 2 * k - 3, -(100 + k));
      add_pin(4, 1, 0, 1, 0);
      beat(5);
    end
    idle(5);

    // rounding at exact halves
    set_all(0, 0, 16384, 0);
    set_lane(0, 5, 0, 8192, 0);
    set_lane(1, 7, 0, 8192, 0);
    set_lane(2, -5, 0, 8192, 0);
    set_lane(3, 0, 5, 8192, 0);
    pin_lane(4, 0, RND5, 0);
    pin_lane(4, 1, 4, 0);
    pin_lane(4, 2, -2, 0);
    pin_lane(4, 3, 0, RND5);
    beat(5);
    idle(5);

    // saturation both directions, then a plain clear
    set_all(DMAX, -DMAX, 16384, 16384);
    set_lane(1, DMAX, -DMAX, -16384, -16384);
    pin_lane(4, 0, DMAX, 0);
    pin_lane(4, 1, DMIN, 0);
    add_pin(3, 2, 0, 0, 0);
    add_pin(4, 2, 0, 1, 0);
    beat(5);
    idle(6);
    sat_clr = 1'b1;
    add_pin(0, 2, 0, 1, 0);
    add_pin(1, 2, 0, 0, 0);
    tick();
    sat_clr = 1'b0;
    idle(2);

    // clear coinciding with a saturating beat leaves the flag set
    set_all(DMAX, -DMAX, 16384, 16384);
    add_pin(3, 2, 0, 0, 0);
    add_pin(4, 2, 0, 1, 0);
    beat(5);
    idle(2);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    idle(3);
    sat_clr = 1'b1;
    add_pin(1, 2, 0, 0, 0);
    tick();
    sat_clr = 1'b0;
    idle(2);

    // per-beat lane mask
    set_all(10, 20, 16384, 0);
    set_lane(3, DMAX, -DMAX, 16384, 16384);
    set_lane(4, DMAX, -DMAX, 16384, 16384);
    pin_lane(4, 2, 10, 20);
    pin_lane(4, 3, 0, 0);
    pin_lane(4, 4, 0, 0);
    add_pin(4, 2, 0, 0, 0);
    add_pin(5, 2, 0, 0, 0);
    beat(3);
    set_all(11, 22, 16384, 0);
    pin_lane(4, 3, 11, 22);
    pin_lane(4, 4, 11, 22);
    beat(5);
    set_all(12, -1, 16384, 0);
    pin_lane(4, 4, 12, -1);
    beat(0);
    set_all(13, 1, 16384, 0);
    pin_lane(4, 1, 13, 1);
    pin_lane(4, 2, 0, 0);
    beat(2);
    set_all(14, 2, 16384, 0);
    pin_lane(4, 4, 14, 2);
    beat(7);
    set_all(15, 3, 16384, 0);
    set_lane(4, DMAX, -DMAX, 16384, 16384);
    pin_lane(4, 3, 15, 3);
    pin_lane(4, 4, 0, 0);
    add_pin(4, 2, 0, 0, 0);
    beat(4);
    idle(6);

    // reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      set_all(200 + k, k, 16384, 0);
      beat(5);
    end
    rst = 1'b1;
    set_all(300, 0, 16384, 0);
    for (int d = 1; d <= 4; d++) begin
      add_pin(d, 1, 0, 0, 0);
      pin_lane(d, 0, 0, 0);
    end
    beat(5);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_all(400 + k, -k, 16384, 0);
      if (k == 0) begin
        pin_lane(4, 0, 400, 0);
        add_pin(4, 1, 0, 1, 0);
      end
      beat(5);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twdl_cmul_pfa.md
Name: twdl_cmul_PFA

Overview:
- Pipelined complex-multiply stage directly downstream of the PFA twiddle ROM stage.
- Consumes 5 data lanes plus the 5 matching twiddle values and multiplies each lane by its twiddle.
- Rounds and saturates each product back to the data width.
- Zeroes lanes beyond the active radix (factor) and feeds the next radix butterfly stage.

Parameters:
wDataInOut, 30, signed data width per real/imag component.
wTw, 16, signed twiddle width; twiddle format Q2.(wTw-2), so 1.0 = 2^(wTw-2) = 16384.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous reset, active-high.
factor  in  3  active radix 2..5; lanes with index >= factor are output as zero.
in_val  in  1  input lane data/twiddles valid this cycle.
din_real  in  [0:4][wDataInOut]  lane data, real.
din_imag  in  [0:4][wDataInOut]  lane data, imag.
tw_real  in  [0:4][wTw]  twiddle, real, cycle-aligned with din.
tw_imag  in  [0:4][wTw]  twiddle, imag, cycle-aligned with din.
sat_clr  in  1  clears sat_sticky.
out_val  out  1  dout valid.
dout_real  out  [0:4][wDataInOut]  product, real.
dout_imag  out  [0:4][wDataInOut]  product, imag.
sat_sticky  out  1  a saturation occurred since the last clear/reset.

Behaviour:
- Reset: out_val=0, dout_real/dout_imag=0, sat_sticky=0, all pipeline valids=0. Reset mid-stream flushes in-flight data; no out_val for 4 cycles after rst deasserts, even if in_val=1 on the first post-reset cycle.
- Pipeline, 4 register stages, latency exactly 4 cycles in_val->out_val. There is no backpressure; one input per cycle, gaps allowed, and valids shift with the data.
  - S1: register din, tw and factor together; factor is sampled per beat.
  - S2: four signed products per lane: dr*tr, di*ti, dr*ti, di*tr, each wDataInOut+wTw bits.
  - S3: re = dr*tr - di*ti; im = dr*ti + di*tr; width wDataInOut+wTw+1, sign-extended, no loss.
  - S4: round, shift, saturate, lane mask; output register.
- Rounding (default): add 2^(wTw-3), then arithmetic shift right by wTw-2 (round half toward +inf).
- Saturation: clamp to [-2^(wDataInOut-1), 2^(wDataInOut-1)-1] after the shift.
- Lane mask: lanes with index >= factor (S1-sampled) are forced to 0 and never flag saturation. factor values 0, 1, 6, 7 are treated as 5.
- When out_val=0, dout is forced to 0.
- sat_sticky: set when any unmasked lane of a valid output beat saturates, re or im. Cleared by sat_clr. A set and a clear in the same cycle leave it set.
- Lane 0 is always multiplied; no hard-wired bypass, since upstream supplies tw=1.0 on lane 0.

Optional Feature:
- Macro CONV_ROUND_EN.
  - Defined: S4 uses round-half-to-even. If the discarded bits are exactly half and the kept LSB is 0, no increment; otherwise identical to default.
  - Undefined: round half up as above.
- Latency and saturation are unchanged either way.

Test Plan:
- Unity twiddle: factor=5, all lanes din=(1000,-7), tw=(16384,0), one beat -> 4 cycles later out_val=1 for 1 cycle, all lanes (1000,-7), sat_sticky=0.
- -j twiddle: lane 2 din=(3,5), tw=(0,-16384) -> lane 2 out (5,-3). Back-to-back 8 beats with an incrementing din give 8 consecutive correct out_val beats in order.
- Rounding: din=(5,0), tw=(8192,0) (0.5) -> out re=3 by default, re=2 with CONV_ROUND_EN. din=(7,0) -> 4 in both builds.
- Saturation: din=(2^29-1, -(2^29-1)), tw=(16384,16384) -> re clamps to 2^29-1, im=0, sat_sticky=1. sat_clr and a saturating beat in the same cycle -> sat_sticky stays 1. sat_clr alone -> sat_sticky=0 the next cycle.
- Lane mask: factor=3, all lanes non-zero with saturating values on lanes 3 and 4 -> lanes 3 and 4 out (0,0), sat_sticky stays 0. Next beat factor=5 -> all lanes non-zero, showing factor is applied per beat.
- Reset mid-stream: in_val=1 continuously, assert rst for 1 cycle while 3 beats are in flight -> out_val=0 and dout=0 for the following 4 cycles; the first post-reset output matches the first post-reset input.
